// File: rtl/main_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ requesters.
// Optional issue/stall counters are compiled in with MAIN_MUL_ARB_STATS_EN.
module main_mul_arbiter #(
  parameter int NREQ   = 4,
  parameter int DIN0_W = 42,
  parameter int DIN1_W = 33,
  parameter int DOUT_W = 75,
  parameter int LAT    = 1,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DIN0_W-1:0]   req_din0,
  input  logic [NREQ*DIN1_W-1:0]   req_din1,
  output logic                     mul_ce,
  output logic [DIN0_W-1:0]        mul_din0,
  output logic [DIN1_W-1:0]        mul_din1,
  input  logic [DOUT_W-1:0]        mul_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DOUT_W-1:0]        out_data,
  output logic [IDW-1:0]           out_id
`ifdef MAIN_MUL_ARB_STATS_EN
  ,
  output logic [31:0]              stat_issue,
  output logic [31:0]              stat_stall
`endif
);

  logic [IDW-1:0]          r_ptr;
  logic [LAT-1:0]          r_vld;
  logic [LAT-1:0][IDW-1:0] r_id;

  logic                    w_ce;
  logic                    w_gnt_any;
  logic [IDW-1:0]          w_gnt_idx;
  logic [IDW:0]            w_idx;

  // The whole multiplier pipe advances together; a held result freezes it.
  assign w_ce      = !r_vld[LAT-1] || out_ready;
  assign mul_ce    = w_ce;
  assign out_valid = r_vld[LAT-1];
  assign out_id    = r_id[LAT-1];
  assign out_data  = mul_dout;

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
      if (!w_gnt_any && req_valid[w_idx[IDW-1:0]] && w_ce && reset_n) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (w_gnt_any) begin
      req_ready[w_gnt_idx] = 1'b1;
      mul_din0 = req_din0[w_gnt_idx*DIN0_W +: DIN0_W];
      mul_din1 = req_din1[w_gnt_idx*DIN1_W +: DIN1_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      r_id  <= '0;
      r_ptr <= '0;
    end else if (w_ce) begin
      r_vld[0] <= w_gnt_any;
      r_id[0]  <= w_gnt_idx;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
      if (w_gnt_any)
        r_ptr <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

`ifdef MAIN_MUL_ARB_STATS_EN
  logic [31:0] r_stat_issue;
  logic [31:0] r_stat_stall;

  assign stat_issue = r_stat_issue;
  assign stat_stall = r_stat_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_issue <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_gnt_any && r_stat_issue != 32'hFFFF_FFFF)
        r_stat_issue <= r_stat_issue + 32'd1;
      if (r_vld[LAT-1] && !out_ready && r_stat_stall != 32'hFFFF_FFFF)
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_main_mul_arbiter.sv
// Scoreboard bench for main_mul_arbiter with a behavioural LAT-stage multiplier.
module tb_main_mul_arbiter;
  localparam int NREQ = 4, D0 = 42, D1 = 33, DO = 75, LAT = 1;
  localparam int IDW = 2;

  logic                 clk = 1'b0, reset_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0, req_ready;
  logic [NREQ*D0-1:0]   req_din0 = '0;
  logic [NREQ*D1-1:0]   req_din1 = '0;
  logic                 mul_ce, out_valid, out_ready = 1'b1;
  logic [D0-1:0]        mul_din0;
  logic [D1-1:0]        mul_din1;
  logic [DO-1:0]        mul_dout, out_data;
  logic [IDW-1:0]       out_id;
`ifdef MAIN_MUL_ARB_STATS_EN
  logic [31:0]          stat_issue, stat_stall;
`endif

  main_mul_arbiter #(.NREQ(NREQ), .DIN0_W(D0), .DIN1_W(D1), .DOUT_W(DO), .LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1), .mul_ce(mul_ce), .mul_din0(mul_din0),
    .mul_din1(mul_din1), .mul_dout(mul_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
`ifdef MAIN_MUL_ARB_STATS_EN
    , .stat_issue(stat_issue), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // unreset multiplier, advances only on mul_ce
  logic [DO-1:0] mpipe [LAT];
  always @(posedge clk)
    if (mul_ce) begin
      mpipe[0] <= {{(DO-D0){1'b0}}, mul_din0} * {{(DO-D1){1'b0}}, mul_din1};
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  assign mul_dout = mpipe[LAT-1];

  typedef struct packed { logic [IDW-1:0] id; logic [DO-1:0] prod; } sb_t;
  sb_t sb_q [$];
  int  n_tot = 0, n_bad = 0, eptr = 0, n_issue = 0, n_stall = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // reference arbiter + scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_ovalid", out_valid, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_ce", mul_ce, 1);
`ifdef MAIN_MUL_ARB_STATS_EN
      chk("rst_stat_issue", stat_issue, 0);
      chk("rst_stat_stall", stat_stall, 0);
`endif
      sb_q.delete();
      eptr = 0; n_issue = 0; n_stall = 0;
    end else begin
      logic exp_ce;
      logic [NREQ-1:0] exp_rdy;
      int g;
      exp_ce = !out_valid || out_ready;
      chk("mul_ce", mul_ce, exp_ce);
      g = -1;
      if (exp_ce)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(eptr + k) % NREQ]) g = (eptr + k) % NREQ;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("out_id", out_id, e.id);
          chk("out_data", out_data, e.prod);
        end
      end
      if (out_valid && !out_ready) n_stall++;
      if (g >= 0) begin
        sb_t e;
        e.id   = IDW'(g);
        e.prod = {{(DO-D0){1'b0}}, req_din0[g*D0 +: D0]} * {{(DO-D1){1'b0}}, req_din1[g*D1 +: D1]};
        sb_q.push_back(e);
        eptr = (g + 1) % NREQ;
        n_issue++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rnd_din();
    for (int i = 0; i < NREQ; i++) begin
      req_din0[i*D0 +: D0] = D0'({$urandom, $urandom});
      req_din1[i*D1 +: D1] = D1'({$urandom, $urandom});
    end
  endtask

  initial begin
    logic [DO-1:0]  cap_d;
    logic [IDW-1:0] cap_id;
    int w;
    rnd_din();
    repeat (3) step();
    reset_n = 1'b1;

    // continuous requests from everyone: strict 0,1,2,3 rotation
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin rnd_din(); step(); end

    // full-width corner operands from requester 2 alone
    req_valid = 4'b0100;
    req_din0[2*D0 +: D0] = 42'h3FF_FFFF_FFFF;
    req_din1[2*D1 +: D1] = 33'h1_FFFF_FFFF;
    step();
    req_valid = '0;
    @(negedge clk);
    chk("corner_ovalid", out_valid, 1);
    chk("corner_id", out_id, 2);
    step(); step();

    // back-pressure: hold output for 5 cycles, then drain without bubbles
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin rnd_din(); step(); end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin cap_d = out_data; cap_id = out_id; end
      chk("stall_ce", mul_ce, 0);
      chk("stall_ready", req_ready, 0);
      chk("stall_data", out_data, cap_d);
      chk("stall_id", out_id, cap_id);
    end
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("nogap_ovalid", out_valid, 1);
      step(); rnd_din();
    end

    // lone requester 3 then lone requester 0: back-to-back grants
    req_valid = 4'b1000;
    @(negedge clk); chk("grant3", req_ready, 4'b1000);
    step();
    req_valid = 4'b0001;
    @(negedge clk); chk("grant0", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step(); step();

    // reset with one op in flight
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk); chk("post_rst_ovalid", out_valid, 0);
    step();
    req_valid = 4'b1110;
    @(negedge clk); chk("post_rst_grant", req_ready, 4'b0010);
    step();

    // random traffic and random back-pressure
    for (int c = 0; c < 40; c++) begin
      req_valid = NREQ'($urandom);
      out_ready = 1'($urandom);
      rnd_din();
      step();
    end

    req_valid = '0;
    out_ready = 1'b1;
    w = 0;
    while (sb_q.size() != 0 && w < 20) begin step(); w++; end
    @(negedge clk);
    chk("drain_empty", sb_q.size(), 0);
`ifdef MAIN_MUL_ARB_STATS_EN
    chk("stat_issue", stat_issue, n_issue);
    chk("stat_stall", stat_stall, n_stall);
`endif
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
